// File: rtl/amba_axi4_lite_master.sv
// AXI4-Lite manager: turns single-beat valid/ready commands into AXI4-Lite
// write/read transactions and returns one response per command. Only one
// transaction is outstanding at a time. A watchdog aborts a transaction that
// waits too long on a handshake.
module amba_axi4_lite_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARST,
  // command port
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_write,
  input  logic [ADDR_W-1:0]   i_cmd_addr,
  input  logic [DATA_W-1:0]   i_cmd_data,
  input  logic [DATA_W/8-1:0] i_cmd_strb,
  // response port
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_data,
  output logic [1:0]          o_rsp_resp,
  output logic                o_rsp_timeout,
  // write address channel
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [2:0]          AWPROT,
  // write data channel
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  // write response channel
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  // read address channel
  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [2:0]          ARPROT,
  // read data channel
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              exit_hs;
  logic              wait_state;
  logic              timeout_hit;

  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;

  assign wait_state  = (state == WR_AW_W) || (state == WR_B) ||
                       (state == RD_AR)   || (state == RD_R);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Handshake that lets the current wait state advance this cycle.
  always_comb begin
    exit_hs = 1'b0;
    case (state)
      WR_AW_W: exit_hs = (!AWVALID || AWREADY) && (!WVALID || WREADY);
      WR_B:    exit_hs = BVALID;
      RD_AR:   exit_hs = ARREADY;
      RD_R:    exit_hs = RVALID;
      default: exit_hs = 1'b0;
    endcase
  end

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state         <= IDLE;
      cnt           <= '0;
      o_cmd_ready   <= 1'b1;
      o_rsp_valid   <= 1'b0;
      o_rsp_data    <= '0;
      o_rsp_resp    <= 2'b00;
      o_rsp_timeout <= 1'b0;
      AWVALID       <= 1'b0;
      AWADDR        <= '0;
      WVALID        <= 1'b0;
      WDATA         <= '0;
      WSTRB         <= '0;
      BREADY        <= 1'b0;
      ARVALID       <= 1'b0;
      ARADDR        <= '0;
      RREADY        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid && o_cmd_ready) begin
            o_cmd_ready <= 1'b0;
            cnt         <= '0;
            if (i_cmd_write) begin
              state   <= WR_AW_W;
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              AWADDR  <= i_cmd_addr;
              WDATA   <= i_cmd_data;
              WSTRB   <= STRB_W'(i_cmd_strb);
            end else begin
              state   <= RD_AR;
              ARVALID <= 1'b1;
              ARADDR  <= i_cmd_addr;
            end
          end
        end
        WR_AW_W: begin
          // each channel drops its valid independently after its handshake
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY)  WVALID  <= 1'b0;
          if (exit_hs) begin
            state  <= WR_B;
            BREADY <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WR_B: begin
          if (exit_hs) begin
            state         <= RSP;
            BREADY        <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_resp    <= BRESP;
            o_rsp_data    <= '0;
            o_rsp_timeout <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RD_AR: begin
          if (exit_hs) begin
            state   <= RD_R;
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RD_R: begin
          if (exit_hs) begin
            state         <= RSP;
            RREADY        <= 1'b0;
            o_rsp_valid   <= 1'b1;
            o_rsp_resp    <= RRESP;
            o_rsp_data    <= RDATA;
            o_rsp_timeout <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          o_cmd_ready <= 1'b1;
        end
      endcase

      // watchdog abort overrides the wait-state update; a handshake wins
      if (wait_state && !exit_hs && timeout_hit) begin
        state         <= RSP;
        AWVALID       <= 1'b0;
        WVALID        <= 1'b0;
        BREADY        <= 1'b0;
        ARVALID       <= 1'b0;
        RREADY        <= 1'b0;
        o_rsp_valid   <= 1'b1;
        o_rsp_resp    <= RESP_SLVERR;
        o_rsp_data    <= '0;
        o_rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
